// File: rtl/button_dir_ctrl.sv
// Debounces four synchronized buttons, emits press pulses and turns them into a
// snake direction request that is committed to the game on the tick strobe.
module button_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter logic [1:0]  START_DIR       = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_sync,
  input  logic       step,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [1:0] dir,
  output logic [1:0] pending_dir,
  output logic       pending_valid
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    pressed;
  logic [CW-1:0] cnt      [4];
  logic [CW-1:0] cnt_next [4];
  logic [3:0]    level_next;
  logic [3:0]    press_next;
  logic [1:0]    cand;
  logic          has_cand;
  logic          commit;
  logic [1:0]    dir_next;
  logic          accept;

  // Normalise button polarity so 1 always means pressed
  always_comb begin
    pressed = 4'b0000;
    if (ACTIVE_LOW) begin
      pressed = ~btn_sync;
    end else begin
      pressed = btn_sync;
    end
  end

  // Per-button debounce: a level flips only after a full run of differing samples
  always_comb begin
    level_next = btn_level;
    press_next = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (pressed[i] == btn_level[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        cnt_next[i]   = '0;
        level_next[i] = ~btn_level[i];
        press_next[i] = ~btn_level[i];
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Fixed-priority candidate UP > DOWN > LEFT > RIGHT
  always_comb begin
    cand     = 2'b11;
    has_cand = |btn_press;
    if (btn_press[0]) begin
      cand = 2'b00;
    end else if (btn_press[1]) begin
      cand = 2'b01;
    end else if (btn_press[2]) begin
      cand = 2'b10;
    end else begin
      cand = 2'b11;
    end
  end

  // Commit happens first; the candidate is judged against the resulting direction
  always_comb begin
    commit   = step & pending_valid;
    dir_next = dir;
    if (commit) begin
      dir_next = pending_dir;
    end else begin
      dir_next = dir;
    end
    accept = has_cand && (cand != dir_next) && (cand != (dir_next ^ 2'b01));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level     <= 4'b0000;
      btn_press     <= 4'b0000;
      dir           <= START_DIR;
      pending_dir   <= START_DIR;
      pending_valid <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_level <= level_next;
      btn_press <= press_next;
      dir       <= dir_next;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
      if (accept) begin
        pending_dir   <= cand;
        pending_valid <= 1'b1;
      end else if (commit) begin
        pending_dir   <= pending_dir;
        pending_valid <= 1'b0;
      end else begin
        pending_dir   <= pending_dir;
        pending_valid <= pending_valid;
      end
    end
  end

endmodule

// File: tb/tb_button_dir_ctrl.sv
// Directed bench for button_dir_ctrl with a 4-cycle debounce and active-low keys.
module tb_button_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_sync = 4'b1111;
  logic       step = 1'b0;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [1:0] dir;
  logic [1:0] pending_dir;
  logic       pending_valid;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  button_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1),
    .START_DIR(2'b11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_sync(btn_sync),
    .step(step),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .dir(dir),
    .pending_dir(pending_dir),
    .pending_valid(pending_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // hold mask pressed long enough to debounce and register the request, then release
  task automatic press_release(input logic [3:0] mask);
    btn_sync = ~mask;
    cyc(5);
    btn_sync = 4'b1111;
    cyc(4);
  endtask

  task automatic do_step();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
  endtask

  initial begin
    // 1. reset with random inputs
    rst = 1'b1;
    btn_sync = 4'($urandom_range(0, 15));
    cyc(1);
    btn_sync = 4'($urandom_range(0, 15));
    cyc(1);
    chk("rst_level", {4'h0, btn_level}, 8'h00);
    chk("rst_press", {4'h0, btn_press}, 8'h00);
    chk("rst_dir", {6'h0, dir}, 8'h03);
    chk("rst_pdir", {6'h0, pending_dir}, 8'h03);
    chk("rst_pvalid", {7'h0, pending_valid}, 8'h00);
    rst = 1'b0;
    btn_sync = 4'b1111;
    cyc(1);
    btn_sync = 4'b1110;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("rst_mid_debounce", {4'h0, btn_level}, 8'h00);
    btn_sync = 4'b1111;
    cyc(2);

    // 2. bounce rejected, stable press accepted
    for (int k = 0; k < 5; k++) begin
      btn_sync = 4'b1110;
      cyc(3);
      btn_sync = 4'b1111;
      cyc(1);
    end
    chk("bounce_level", {4'h0, btn_level}, 8'h00);
    btn_sync = 4'b1110;
    cyc(3);
    chk("deb_edge3_level", {4'h0, btn_level}, 8'h00);
    cyc(1);
    chk("deb_edge4_level", {4'h0, btn_level}, 8'h01);
    chk("deb_edge4_press", {4'h0, btn_press}, 8'h01);
    cyc(1);
    chk("press_one_cycle", {4'h0, btn_press}, 8'h00);
    chk("up_pdir", {6'h0, pending_dir}, 8'h00);
    chk("up_pvalid", {7'h0, pending_valid}, 8'h01);
    chk("up_dir_not_yet", {6'h0, dir}, 8'h03);
    do_step();
    chk("step_dir_up", {6'h0, dir}, 8'h00);
    chk("step_pvalid_clr", {7'h0, pending_valid}, 8'h00);
    btn_sync = 4'b1111;
    cyc(4);
    chk("release_level", {4'h0, btn_level}, 8'h00);

    // back to RIGHT
    press_release(4'b1000);
    do_step();
    chk("dir_right", {6'h0, dir}, 8'h03);

    // 3. reversal and same-direction rejected
    press_release(4'b0100);
    chk("left_rev_reject", {7'h0, pending_valid}, 8'h00);
    press_release(4'b1000);
    chk("right_same_reject", {7'h0, pending_valid}, 8'h00);
    do_step();
    chk("idle_step_dir", {6'h0, dir}, 8'h03);

    // 4. latest request wins, priority on simultaneous presses
    press_release(4'b0001);
    chk("latest_up_pdir", {6'h0, pending_dir}, 8'h00);
    press_release(4'b0010);
    chk("latest_down_pdir", {6'h0, pending_dir}, 8'h01);
    chk("latest_pvalid", {7'h0, pending_valid}, 8'h01);
    do_step();
    chk("latest_dir", {6'h0, dir}, 8'h01);
    press_release(4'b1000);
    do_step();
    chk("dir_right2", {6'h0, dir}, 8'h03);
    press_release(4'b0011);
    chk("prio_pdir", {6'h0, pending_dir}, 8'h00);
    chk("prio_pvalid", {7'h0, pending_valid}, 8'h01);

    // 5. step collides with a DOWN press: reversal of the new direction
    btn_sync = 4'b1101;
    cyc(4);
    chk("coll_down_pulse", {4'h0, btn_press}, 8'h02);
    do_step();
    chk("coll_down_dir", {6'h0, dir}, 8'h00);
    chk("coll_down_pvalid", {7'h0, pending_valid}, 8'h00);
    btn_sync = 4'b1111;
    cyc(4);
    press_release(4'b1000);
    do_step();
    press_release(4'b0001);
    chk("coll2_setup_dir", {6'h0, dir}, 8'h03);
    btn_sync = 4'b1011;
    cyc(4);
    chk("coll_left_pulse", {4'h0, btn_press}, 8'h04);
    do_step();
    chk("coll_left_dir", {6'h0, dir}, 8'h00);
    chk("coll_left_pdir", {6'h0, pending_dir}, 8'h02);
    chk("coll_left_pvalid", {7'h0, pending_valid}, 8'h01);
    btn_sync = 4'b1111;
    cyc(4);

    // 6. long hold, glitch while held, release
    btn_sync = 4'b1110;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1);
      if (btn_press[0]) pulses++;
    end
    chk("hold_pulses", 8'(pulses), 8'h01);
    chk("hold_level", {4'h0, btn_level}, 8'h01);
    btn_sync = 4'b1111;
    cyc(3);
    btn_sync = 4'b1110;
    cyc(1);
    chk("glitch_level", {4'h0, btn_level}, 8'h01);
    btn_sync = 4'b1111;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      if (btn_press != 4'b0000) pulses++;
    end
    chk("release_level2", {4'h0, btn_level}, 8'h00);
    chk("release_no_pulse", 8'(pulses), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_dir_ctrl.md
Name: button_dir_ctrl

Overview:
- Sits directly downstream of the 2-flop button synchronizer in the snake game.
- Debounces the four synchronized user buttons and emits one-cycle press pulses.
- Turns presses into a movement-direction request, rejecting reversals into the snake's own body.
- Commits the requested direction to the game logic only on the game-tick strobe.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive differing samples required to accept a level change (20 ms at 50 MHz); legal range >= 2.
ACTIVE_LOW, 1, 1 = buttons read 0 when pressed (board KEYs); 0 = active-high.
START_DIR, 2'b11, direction loaded on reset.

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous reset, active-high
btn_sync  input  4  synchronized buttons: bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT
step  input  1  game-tick strobe, one cycle; commits pending direction
btn_level  output  4  debounced pressed level per button, 1 = pressed
btn_press  output  4  one-cycle pulse per button on debounced press
dir  output  2  committed direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
pending_dir  output  2  requested direction awaiting step
pending_valid  output  1  pending_dir holds an accepted, uncommitted request

Behaviour:
- Reset: one cycle of rst at a clk edge gives btn_level=0, btn_press=0, all debounce counters=0, dir=START_DIR, pending_dir=START_DIR, pending_valid=0.
  - rst has priority over every other event.
  - Reset mid-debounce discards partial counts.
- Polarity: p = ACTIVE_LOW ? ~btn_sync : btn_sync.
- Debounce, independent per bit i (4 counters, width $clog2(DEBOUNCE_CYCLES)):
  - Edge sampling p[i]==btn_level[i]: counter cleared to 0.
  - Edge sampling p[i]!=btn_level[i]: counter increments.
  - If the counter already equals DEBOUNCE_CYCLES-1 at that edge, btn_level[i] toggles and the counter clears instead.
  - Net effect: btn_level changes at the DEBOUNCE_CYCLES-th consecutive differing edge.
  - Any agreeing sample restarts the count. No wrap is possible.
- Press pulse: btn_press[i] is 1 in exactly the cycle in which btn_level[i] first reads 1 after a 0→1 change; otherwise 0. Release produces no pulse.
- Candidate: if any btn_press bit is set, select one by fixed priority UP > DOWN > LEFT > RIGHT and encode it as cand.
- Commit: at an edge with step=1 and pending_valid=1, dir_next = pending_dir; otherwise dir_next = dir. step with pending_valid=0 leaves all state unchanged.
- Acceptance: a candidate is rejected if cand == dir_next or cand == (dir_next ^ 2'b01), i.e. same direction or reversal.
  - Accepted: pending_dir <= cand, pending_valid <= 1. A later accepted press overwrites an uncommitted one (latest wins).
  - Rejected: pending_dir and pending_valid unchanged, except that a commit in the same edge still clears pending_valid.
- Simultaneous step and press at one edge:
  - The commit happens first.
  - The press is judged against the newly committed direction.
  - If accepted, it becomes the new pending and pending_valid stays 1.
- Latency:
  - Stable press to btn_level/btn_press: DEBOUNCE_CYCLES edges.
  - btn_press to pending_valid: 1 edge.
  - step to dir: 1 edge.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan (bench uses DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, START_DIR=11):
1. Reset: rst high 2 cycles with random btn_sync → btn_level=0000, btn_press=0000, dir=11, pending_valid=0; repeat rst after a partial 3-cycle press → counter cleared, no btn_level change.
2. Bounce reject / accept:
   - btn_sync[0] low 3 cycles, high 1, repeated 5 times → btn_level stays 0000.
   - Then low 4 cycles → btn_level[0]=1 at 4th edge, btn_press=0001 for one cycle, next cycle pending_dir=00, pending_valid=1.
   - step → dir=00, pending_valid=0.
3. Reversal/same reject: dir=11, press LEFT → pending_valid stays 0; press RIGHT → pending_valid stays 0; step → dir stays 11.
4. Latest wins: dir=11, press UP, release, press DOWN, then step → dir=01; press UP and DOWN in one cycle from dir=11 → pending_dir=00 (priority).
5. Step/press collision: dir=11, pending UP, DOWN press pulse at the same edge as step → dir=00, DOWN rejected as reversal, pending_valid=0; same with LEFT instead → dir=00, pending_dir=10, pending_valid=1.
6. Release/hold: hold UP 100 cycles → exactly one btn_press pulse; release for 4 cycles → btn_level[0]=0, no pulse; 3-cycle release glitch → btn_level stays 1.
